conv_ram_reader: RTL and testbench

Read-side engine for the NPU's single-port 8-bit `conv_ram`. It accepts a 2D fetch command: base address, columns, rows, and row stride. It issues one read address per cycle to the RAM and absorbs the RAM's fixed 1-cycle read latency. It delivers the bytes in raster order on a valid/ready stream, with row and frame markers, to the convolution datapath. Backpressure is handled by a small credit-controlled FIFO, so no RAM read result is ever dropped.

---
 rtl/npu_pkg.sv | 21 ++
 rtl/npu_stream_fifo.sv | 57 +++++
 rtl/conv_ram_reader.sv | 181 ++++++++++++++++++
 tb/tb_conv_ram_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU stream types: controller states, datapath widths and the
// tagged byte carried through stream FIFOs.
package npu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              eol;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/npu_stream_fifo.sv
// Synchronous FIFO of tagged stream bytes with an occupancy output.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module npu_stream_fifo
    import npu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  fifo_entry_t      push_data,
    input  logic             pop,
    output fifo_entry_t      head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // a full FIFO still accepts a push when the head leaves in the same cycle
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/conv_ram_reader.sv
// 2D raster fetch engine for conv_ram: credit-limited reads into a stream FIFO.
// Optional stall counter port enabled by CONV_RAM_READER_PERF_EN.
module conv_ram_reader
    import npu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        cols,
    input  logic [7:0]        rows,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_eol,
    output logic              out_last
`ifdef CONV_RAM_READER_PERF_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [7:0]        cols_q, cols_d;
    logic [7:0]        rows_q, rows_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic              eol_tag_q, eol_tag_d;
    logic              last_tag_q, last_tag_d;

    logic [ADDR_W-1:0] cur_addr;
    logic              at_eol, at_last_row, credit_ok, issue, pop;
    fifo_entry_t       push_data, head;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    always_comb begin
        state_d    = state_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        addr_d     = addr_q;
        eol_tag_d  = eol_tag_q;
        last_tag_d = last_tag_q;
        issue      = 1'b0;

        cur_addr    = row_base_q + ADDR_W'(col_q);
        at_eol      = (col_q == cols_q - 8'd1);
        at_last_row = (row_q == rows_q - 8'd1);
        // a pop in this cycle frees credit only from the next cycle on
        credit_ok   = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
        pop         = out_ready && !fifo_empty;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cols_d     = cols;
                    rows_d     = rows;
                    stride_d   = stride;
                    row_base_d = base_addr;
                    col_d      = '0;
                    row_d      = '0;
                    state_d    = (cols != '0 && rows != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    addr_d     = cur_addr;
                    eol_tag_d  = at_eol;
                    last_tag_d = at_eol && at_last_row;
                    if (at_eol) begin
                        col_d      = '0;
                        row_d      = row_q + 8'd1;
                        row_base_d = row_base_q + stride_q;
                        if (at_last_row) state_d = ST_DRAIN;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // leave as the final beat transfers so done follows it directly
                if (!inflight_q && (fifo_empty || (fifo_count == CNT_W'(1) && pop)))
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        inflight_d = issue;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            eol_tag_q  <= 1'b0;
            last_tag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            eol_tag_q  <= eol_tag_d;
            last_tag_q <= last_tag_d;
        end
    end

    assign push_data = '{data: ram_q, eol: eol_tag_q, last: last_tag_q};

    npu_stream_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (inflight_q),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign ram_address = issue ? cur_addr : addr_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign out_valid   = !fifo_empty;
    // stale FIFO storage is masked so idle outputs read as zero
    assign out_data    = out_valid ? head.data : '0;
    assign out_eol     = out_valid && head.eol;
    assign out_last    = out_valid && head.last;

`ifdef CONV_RAM_READER_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_IDLE && start)
            stall_d = '0;
        else if (state_q != ST_IDLE && out_valid && !out_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_ram_reader.sv
// Directed bench for conv_ram_reader: a raster-order byte model feeds a
// per-cycle stream checker, plus literal timing/address expectations.
module tb_conv_ram_reader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  cols = '0;
    logic [7:0]  rows = '0;
    logic [15:0] stride = '0;
    logic        busy, done;
    logic [15:0] ram_address;
    logic [7:0]  ram_q = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_eol, out_last;
`ifdef CONV_RAM_READER_PERF_EN
    logic [15:0] stall_cycles;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] d;
        logic       eol;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    conv_ram_reader #(.FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .cols       (cols),
        .rows       (rows),
        .stride     (stride),
        .busy       (busy),
        .done       (done),
        .ram_address(ram_address),
        .ram_q      (ram_q),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_eol    (out_eol),
        .out_last   (out_last)
`ifdef CONV_RAM_READER_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    // RAM preloaded with mem[a] = a[7:0], one-cycle read latency
    always @(posedge clock) ram_q <= ram_address[7:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected stream: raster order, addr = base + r*stride + c (mod 2^16)
    task automatic model(input logic [15:0] b, input logic [7:0] c, input logic [7:0] r,
                         input logic [15:0] s);
        for (int ri = 0; ri < int'(r); ri++)
            for (int ci = 0; ci < int'(c); ci++) begin
                exp_t e;
                logic [15:0] a;
                a      = b + 16'(ri) * s + 16'(ci);
                e.d    = a[7:0];
                e.eol  = (ci == int'(c) - 1);
                e.last = (ci == int'(c) - 1) && (ri == int'(r) - 1);
                exp_q.push_back(e);
            end
    endtask

    // Per-cycle stream checker against the model
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_rst_n = 1'b0;
    logic [9:0] prev_word = '0;
    always @(negedge clock) begin
        if (reset_n && prev_rst_n) begin
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_word", 32'({out_data, out_eol, out_last}), 32'(prev_word));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) chk("extra_beat", 32'(out_valid), 32'd0);
                else begin
                    chk("beat_data", 32'(out_data), 32'(exp_q[0].d));
                    chk("beat_eol", 32'(out_eol), 32'(exp_q[0].eol));
                    chk("beat_last", 32'(out_last), 32'(exp_q[0].last));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (done) chk("done_drained", 32'(exp_q.size()), 32'd0);
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_rst_n = reset_n;
        prev_word  = {out_data, out_eol, out_last};
    end

    // Runs one command from just after a rising edge; ends just after a rising edge.
    task automatic run_cmd(input logic [15:0] b, input logic [7:0] c, input logic [7:0] r,
                           input logic [15:0] s, input int off_lo, input int off_hi,
                           input int rst_cyc, input int again_cyc, input int addr_cyc,
                           input logic [15:0] addr_exp, input int e_first, input int e_last,
                           input int e_done);
        int first = 0, lastc = 0, donec = 0, fall = 0;
        logic [15:0] addr0;
        model(b, c, r, s);
        addr0     = ram_address;
        base_addr = b;
        cols      = c;
        rows      = r;
        stride    = s;
        start     = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            out_ready = !(k >= off_lo && k <= off_hi);
            if (k == again_cyc) begin
                start = 1'b1; base_addr = 16'h0080; cols = 8'd9; rows = 8'd9;
            end else start = 1'b0;
            if (rst_cyc != 0 && k == rst_cyc) reset_n = 1'b0;
            if (rst_cyc != 0 && k == rst_cyc + 1) begin
                reset_n = 1'b1;
                exp_q.delete();
            end
            @(negedge clock);
            if (c == 0 || r == 0) begin
                chk("zero_addr", 32'(ram_address), 32'(addr0));
                chk("zero_valid", 32'(out_valid), 32'd0);
            end
            if (k == addr_cyc) chk("held_addr", 32'(ram_address), 32'(addr_exp));
            if (rst_cyc != 0 && k == rst_cyc + 1)
                chk("rst_outs", 32'({busy, done, out_valid, out_eol, out_last, out_data, ram_address}), 32'd0);
            if (rst_cyc != 0 && k > rst_cyc) chk("rst_no_done", 32'(done), 32'd0);
            if (out_valid && first == 0) first = k;
            if (out_valid && out_ready && out_last) lastc = k;
            if (done && donec == 0) donec = k;
            if (donec != 0 && !busy && fall == 0) fall = k;
            if (fall != 0 || (rst_cyc != 0 && k == rst_cyc + 6)) break;
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        if (rst_cyc == 0) begin
            chk("t_first_valid", 32'(first), 32'(e_first));
            chk("t_last_beat", 32'(lastc), 32'(e_last));
            chk("t_done", 32'(donec), 32'(e_done));
            chk("t_busy_fall", 32'(fall), 32'(e_done + 1));
            chk("all_beats", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outs", 32'({busy, done, out_valid, out_eol, out_last, out_data, ram_address}), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // model pins: hand-computed bytes
        model(16'h0010, 8'd3, 8'd2, 16'h0008);
        chk("model_b0", 32'(exp_q[0].d), 32'h10);
        chk("model_b3", 32'(exp_q[3].d), 32'h18);
        chk("model_b5", 32'({exp_q[5].d, exp_q[5].eol, exp_q[5].last}), 32'({8'h1A, 2'b11}));
        chk("model_eol2", 32'({exp_q[2].eol, exp_q[2].last}), 32'b10);
        exp_q.delete();
        model(16'hFFFE, 8'd4, 8'd1, 16'h0000);
        chk("model_wrap", 32'(exp_q[2].d), 32'h00);
        exp_q.delete();

        // basic 3x2 frame, full throughput
        run_cmd(16'h0010, 8'd3, 8'd2, 16'h0008, 0, 0, 0, 0, 0, 16'h0, 3, 8, 9);
        // backpressure cycles 3..12: four bytes buffered, address parked at 0x18
        run_cmd(16'h0010, 8'd3, 8'd2, 16'h0008, 3, 12, 0, 0, 12, 16'h0018, 3, 18, 19);
        // address wrap
        run_cmd(16'hFFFE, 8'd4, 8'd1, 16'h0000, 0, 0, 0, 0, 4, 16'h0001, 3, 6, 7);
        // zero dimensions
        run_cmd(16'h1234, 8'd5, 8'd0, 16'h0001, 0, 0, 0, 0, 0, 16'h0, 0, 0, 1);
        run_cmd(16'h4321, 8'd0, 8'd3, 16'h0001, 0, 0, 0, 0, 0, 16'h0, 0, 0, 1);
        // second start mid-frame is ignored
        run_cmd(16'h0020, 8'd3, 8'd2, 16'h0010, 0, 0, 0, 4, 0, 16'h0, 3, 8, 9);
        // reset after the 2nd beat abandons the frame
        run_cmd(16'h0040, 8'd6, 8'd1, 16'h0000, 0, 0, 5, 0, 0, 16'h0, 0, 0, 0);
        run_cmd(16'h0010, 8'd3, 8'd2, 16'h0008, 0, 0, 0, 0, 0, 16'h0, 3, 8, 9);
`ifdef CONV_RAM_READER_PERF_EN
        run_cmd(16'h0010, 8'd3, 8'd2, 16'h0008, 3, 9, 0, 0, 0, 16'h0, 3, 15, 16);
        chk("stall_count", 32'(stall_cycles), 32'd7);
        run_cmd(16'h0010, 8'd3, 8'd2, 16'h0008, 0, 0, 0, 0, 0, 16'h0, 3, 8, 9);
        chk("stall_clear", 32'(stall_cycles), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
